// File: rtl/atm_session_ctrl_if.sv
// Bank request/response channel between the ATM session controller (master)
// and the account bank (slave).
interface atm_session_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_select;
    logic [3:0] req_origin;
    logic [3:0] req_purpose;
    logic [9:0] req_amount;
    logic       resp_valid;
    logic [1:0] resp_result;
    logic [9:0] resp_inventory;

    modport master (
        output req_valid, req_select, req_origin, req_purpose, req_amount,
        input  req_ready, resp_valid, resp_result, resp_inventory
    );

    modport slave (
        input  req_valid, req_select, req_origin, req_purpose, req_amount,
        output req_ready, resp_valid, resp_result, resp_inventory
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN checking, operation collection, one bank
// request at a time, outcome reporting, retry lockout and inactivity timeouts.
module atm_session_ctrl #(
    parameter logic [3:0] DEFAULT_PIN  = 4'hA,
    parameter int         MAX_TRIES    = 3,
    parameter int         IDLE_TIMEOUT = 1000,
    parameter int         RESP_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_card_valid,
    input  logic [3:0]                i_card_acc,
    input  logic                      i_pin_valid,
    input  logic [3:0]                i_pin,
    input  logic                      i_op_valid,
    input  logic [1:0]                i_op_sel,
    input  logic [9:0]                i_op_amount,
    input  logic [3:0]                i_op_dest,
    input  logic                      i_cancel,
    atm_session_ctrl_if.master        bank,
    output logic                      o_done,
    output logic [2:0]                o_status,
    output logic [9:0]                o_balance_out,
    output logic                      o_card_eject,
    output logic [14:0]               o_locked
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PIN  = 3'd1,
        S_WAIT_OP   = 3'd2,
        S_REQ       = 3'd3,
        S_WAIT_RESP = 3'd4,
        S_REPORT    = 3'd5
    } state_t;

    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam int RW = $clog2(RESP_TIMEOUT);
    localparam int NW = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_NOFUNDS = 3'd1;
    localparam logic [2:0] ST_BADPIN  = 3'd2;
    localparam logic [2:0] ST_LOCKED  = 3'd3;
    localparam logic [2:0] ST_INVALID = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;
    localparam logic [2:0] ST_CANCEL  = 3'd6;
    localparam logic [2:0] ST_BANKERR = 3'd7;

    state_t          r_state;
    state_t          w_next;
    state_t          r_ret;
    state_t          w_rep_ret;
    logic            w_rep;
    logic [2:0]      w_rep_status;
    logic [NW-1:0]   r_tries;
    logic [NW-1:0]   w_tries_nxt;
    logic [NW-1:0]   w_tries_inc;
    logic            w_lock_set;
    logic            w_acc_load;
    logic            w_req_load;
    logic            w_bal_load;
    logic            w_idle_to;
    logic            w_resp_to;
    logic            w_op_bad;
    logic            w_in_wait;
    logic            w_bank_phase;
    logic [3:0]      r_acc;
    logic [TW-1:0]   r_timer;
    logic [RW-1:0]   r_rtimer;
    logic [14:0]     r_locked;
    logic            r_done;
    logic            r_eject;
    logic [2:0]      r_status;
    logic [9:0]      r_balance;
    logic            r_req_valid;
    logic [1:0]      r_req_select;
    logic [3:0]      r_req_purpose;
    logic [9:0]      r_req_amount;

    assign w_tries_inc  = r_tries + NW'(1);
    assign w_idle_to    = (r_timer == TW'(IDLE_TIMEOUT - 1));
    assign w_resp_to    = (r_rtimer == RW'(RESP_TIMEOUT - 1));
    assign w_in_wait    = (r_state == S_WAIT_PIN) || (r_state == S_WAIT_OP);
    assign w_bank_phase = ((r_state == S_REQ) || (r_state == S_WAIT_RESP)) &&
                          ((w_next == S_REQ) || (w_next == S_WAIT_RESP));
    // Withdraw/transfer need an amount; a transfer needs a real, different account.
    assign w_op_bad     = (i_op_sel != 2'd1) &&
                          ((i_op_amount == 10'd0) ||
                           ((i_op_sel == 2'd3) && ((i_op_dest == 4'hF) || (i_op_dest == r_acc))));

    // Next-state and report decision logic.
    always_comb begin
        w_next       = r_state;
        w_rep        = 1'b0;
        w_rep_status = r_status;
        w_rep_ret    = S_IDLE;
        w_tries_nxt  = r_tries;
        w_lock_set   = 1'b0;
        w_acc_load   = 1'b0;
        w_req_load   = 1'b0;
        w_bal_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_card_valid && ((i_card_acc == 4'hF) || r_locked[i_card_acc])) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_LOCKED;
                    w_next       = S_REPORT;
                end else if (i_card_valid) begin
                    w_acc_load  = 1'b1;
                    w_tries_nxt = NW'(0);
                    w_next      = S_WAIT_PIN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_PIN: begin
                if (i_cancel) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_CANCEL;
                    w_next       = S_REPORT;
                end else if (i_pin_valid && (i_pin == DEFAULT_PIN)) begin
                    w_tries_nxt = NW'(0);
                    w_next      = S_WAIT_OP;
                end else if (i_pin_valid && (w_tries_inc == NW'(MAX_TRIES))) begin
                    w_tries_nxt  = NW'(0);
                    w_lock_set   = 1'b1;
                    w_rep        = 1'b1;
                    w_rep_status = ST_LOCKED;
                    w_next       = S_REPORT;
                end else if (i_pin_valid) begin
                    w_tries_nxt  = w_tries_inc;
                    w_rep        = 1'b1;
                    w_rep_status = ST_BADPIN;
                    w_rep_ret    = S_WAIT_PIN;
                    w_next       = S_REPORT;
                end else if (w_idle_to) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_TIMEOUT;
                    w_next       = S_REPORT;
                end else begin
                    w_next = S_WAIT_PIN;
                end
            end
            S_WAIT_OP: begin
                if (i_cancel) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_CANCEL;
                    w_next       = S_REPORT;
                end else if (i_op_valid && (i_op_sel == 2'd0)) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_OK;
                    w_next       = S_REPORT;
                end else if (i_op_valid && w_op_bad) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_INVALID;
                    w_rep_ret    = S_WAIT_OP;
                    w_next       = S_REPORT;
                end else if (i_op_valid) begin
                    w_req_load = 1'b1;
                    w_next     = S_REQ;
                end else if (w_idle_to) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_TIMEOUT;
                    w_next       = S_REPORT;
                end else begin
                    w_next = S_WAIT_OP;
                end
            end
            S_REQ: begin
                if (bank.req_ready) begin
                    w_next = S_WAIT_RESP;
                end else if (w_resp_to) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_BANKERR;
                    w_next       = S_REPORT;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_WAIT_RESP: begin
                if (bank.resp_valid) begin
                    w_rep  = 1'b1;
                    w_next = S_REPORT;
                    case (bank.resp_result)
                        2'd3: begin
                            w_rep_status = ST_OK;
                            w_rep_ret    = S_WAIT_OP;
                            w_bal_load   = (r_req_select == 2'd1);
                        end
                        2'd1, 2'd2: begin
                            w_rep_status = ST_NOFUNDS;
                            w_rep_ret    = S_WAIT_OP;
                        end
                        default: begin
                            w_rep_status = ST_BANKERR;
                        end
                    endcase
                end else if (w_resp_to) begin
                    w_rep        = 1'b1;
                    w_rep_status = ST_BANKERR;
                    w_next       = S_REPORT;
                end else begin
                    w_next = S_WAIT_RESP;
                end
            end
            S_REPORT: begin
                w_next = r_ret;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Session bookkeeping: account, retries, lock bitmap, return state, timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= 4'd0;
            r_tries  <= NW'(0);
            r_locked <= 15'd0;
            r_ret    <= S_IDLE;
            r_timer  <= TW'(0);
            r_rtimer <= RW'(0);
        end else begin
            r_tries <= w_tries_nxt;
            if (w_acc_load) begin
                r_acc <= i_card_acc;
            end
            if (w_lock_set) begin
                r_locked[r_acc] <= 1'b1;
            end
            if (w_rep) begin
                r_ret <= w_rep_ret;
            end
            // Inactivity timer restarts whenever the state changes.
            if (w_in_wait && (w_next == r_state)) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= TW'(0);
            end
            if (w_bank_phase) begin
                r_rtimer <= r_rtimer + RW'(1);
            end else begin
                r_rtimer <= RW'(0);
            end
        end
    end

    // Report outputs: done/eject pulses on REPORT entry, status and balance held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_eject   <= 1'b0;
            r_status  <= 3'd0;
            r_balance <= 10'd0;
        end else begin
            r_done  <= w_rep;
            r_eject <= w_rep && (w_rep_ret == S_IDLE);
            if (w_rep) begin
                r_status <= w_rep_status;
            end
            if (w_bal_load) begin
                r_balance <= bank.resp_inventory;
            end
        end
    end

    // Bank request register: fields frozen from WAIT_OP until acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_valid   <= 1'b0;
            r_req_select  <= 2'd0;
            r_req_purpose <= 4'd0;
            r_req_amount  <= 10'd0;
        end else begin
            r_req_valid <= (w_next == S_REQ);
            if (w_req_load) begin
                r_req_select  <= i_op_sel;
                r_req_purpose <= (i_op_sel == 2'd3) ? i_op_dest : 4'd0;
                r_req_amount  <= (i_op_sel == 2'd1) ? 10'd0 : i_op_amount;
            end
        end
    end

    assign bank.req_valid   = r_req_valid;
    assign bank.req_select  = r_req_select;
    assign bank.req_origin  = r_acc;
    assign bank.req_purpose = r_req_purpose;
    assign bank.req_amount  = r_req_amount;
    assign o_done           = r_done;
    assign o_status         = r_status;
    assign o_balance_out    = r_balance;
    assign o_card_eject     = r_eject;
    assign o_locked         = r_locked;

endmodule
